// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled block RAM plus a small MMIO window
// (tohost mailbox, 64-bit cycle counter); whole words return one cycle after the address.
module dmem_responder #(
    parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEnable,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [31:0] tohost,
    output logic        tohost_valid,
    output logic        addr_err,
    output logic [63:0] cycle
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
    localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];

    logic [31:0]           w_ram_off;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_hit;
    logic                  w_tohost_hit;
    logic                  w_cyc_lo_hit;
    logic                  w_cyc_hi_hit;
    logic                  w_miss;
    logic                  w_err;
    logic                  w_ram_we;
    logic                  w_tohost_we;
    logic [31:0]           w_tohost_next;
    logic [31:0]           w_mmio_rdata;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_ram_rdata;
    logic                  r_rd_ram;
    logic [31:0]           r_mmio_rdata;
    logic [31:0]           r_tohost;
    logic                  r_tohost_valid;
    logic                  r_addr_err;
    logic [63:0]           r_cycle;
    logic [31:0]           r_cycle_hi;

    // Address decode: RAM by byte range, MMIO by word address.
    assign w_ram_off    = Addr - DMEM_BASE;
    assign w_ram_idx    = w_ram_off[ADDR_WIDTH+1:2];
    assign w_ram_hit    = (Addr >= DMEM_BASE) && (w_ram_off < RAM_BYTES);
    assign w_tohost_hit = (Addr[31:2] == MMIO_WORD);
    assign w_cyc_lo_hit = (Addr[31:2] == MMIO_WORD + 30'd1);
    assign w_cyc_hi_hit = (Addr[31:2] == MMIO_WORD + 30'd2);
    assign w_miss       = !(w_ram_hit || w_tohost_hit || w_cyc_lo_hit || w_cyc_hi_hit);

    // High-address misses are speculative ALU garbage and only flag when writing.
    assign w_err        = w_miss && (MemWrite || !Addr[31]);

    // A store presented while reset is held low must not reach the RAM.
    assign w_ram_we     = MemWrite && w_ram_hit && n_rst;
    assign w_tohost_we  = MemWrite && w_tohost_hit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_tohost_next = r_tohost;
        for (int i = 0; i < 4; i++) begin
            if (ByteEnable[i]) begin
                w_tohost_next[8*i +: 8] = WriteData[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_mmio_rdata = 32'h0;
        if (w_tohost_hit) begin
            w_mmio_rdata = r_tohost;
        end else if (w_cyc_lo_hit) begin
            w_mmio_rdata = r_cycle[31:0];
        end else if (w_cyc_hi_hit) begin
            w_mmio_rdata = r_cycle_hi;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array and its read register carry no reset so the RAM maps onto a block RAM.
        r_ram_rdata <= r_mem[w_ram_idx];
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we && ByteEnable[i]) begin
                r_mem[w_ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_rd_ram       <= 1'b0;
            r_mmio_rdata   <= 32'h0;
            r_tohost       <= 32'h0;
            r_tohost_valid <= 1'b0;
            r_addr_err     <= 1'b0;
            r_cycle        <= 64'h0;
            r_cycle_hi     <= 32'h0;
        end else begin
            r_rd_ram     <= w_ram_hit;
            r_mmio_rdata <= w_mmio_rdata;
            r_addr_err   <= w_err;
            r_cycle      <= r_cycle + 64'd1;
            // Latching the high half on a low read keeps a lo-then-hi pair coherent.
            if (w_cyc_lo_hit) begin
                r_cycle_hi <= r_cycle[63:32];
            end
            if (w_tohost_we) begin
                r_tohost <= w_tohost_next;
                if (w_tohost_next[0]) begin
                    r_tohost_valid <= 1'b1;
                end
            end
        end
    end

    assign ReadData     = r_rd_ram ? r_ram_rdata : r_mmio_rdata;
    assign tohost       = r_tohost;
    assign tohost_valid = r_tohost_valid;
    assign addr_err     = r_addr_err;
    assign cycle        = r_cycle;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes expected responses from a
// behavioural memory-map model, the negedge monitor pops and compares them.
module tb_dmem_responder;

    localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
    localparam int          ADDR_WIDTH = 12;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
    localparam logic [31:0] TOHOST     = MMIO_BASE;
    localparam logic [31:0] CYC_LO     = MMIO_BASE + 32'd4;
    localparam logic [31:0] CYC_HI     = MMIO_BASE + 32'd8;
    localparam longint unsigned RAM_BYTES = 64'd4 << ADDR_WIDTH;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [3:0]  ByteEnable;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [31:0] tohost;
    logic        tohost_valid;
    logic        addr_err;
    logic [63:0] cycle;

    dmem_responder #(
        .DMEM_BASE (DMEM_BASE),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .Addr        (Addr),
        .WriteData   (WriteData),
        .ByteEnable  (ByteEnable),
        .MemWrite    (MemWrite),
        .ReadData    (ReadData),
        .tohost      (tohost),
        .tohost_valid(tohost_valid),
        .addr_err    (addr_err),
        .cycle       (cycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        bit          chk;
        bit          err;
        logic [31:0] th;
        bit          tv;
        int          id;
    } exp_t;

    exp_t            q[$];
    exp_t            mon_e;
    int unsigned     cyc = 0;
    longint unsigned edges = 0;
    longint unsigned cyc_offset = 0;
    logic [31:0]     m_mem [int unsigned];
    logic [31:0]     m_tohost;
    bit              m_tv;
    logic [31:0]     m_shadow;
    int              id_ctr = 0;
    int              n_pass = 0;
    int              n_total = 0;
    bit              finish_req = 1'b0;

    // Reference cycle count: edges seen with reset high, plus any preload offset.
    always @(posedge clk) begin
        cyc++;
        if (n_rst) edges++;
        else       edges = 0;
    end

    function automatic longint unsigned model_cycle();
        return cyc_offset + edges;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic check(input int id, input string what, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (txn %0d): got %h, expected %h", what, id, act, exp);
    endtask

    // Drive one cycle of M-stage traffic and record what the memory map must answer.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic we);
        exp_t            e;
        longint unsigned cnow;
        int unsigned     idx;
        bit              ram, th, lo, hi;
        @(posedge clk);
        #2;
        Addr = a; WriteData = wd; ByteEnable = be; MemWrite = we;
        cnow = model_cycle();
        ram  = (64'(a) >= 64'(DMEM_BASE)) && (64'(a) < 64'(DMEM_BASE) + RAM_BYTES);
        idx  = (a - DMEM_BASE) >> 2;
        th   = (a >> 2) == (TOHOST >> 2);
        lo   = (a >> 2) == (CYC_LO >> 2);
        hi   = (a >> 2) == (CYC_HI >> 2);
        e.due = cyc + 1;
        e.id  = id_ctr;
        id_ctr++;
        e.chk  = 1'b1;
        e.data = 32'h0;
        if (ram) begin
            if (m_mem.exists(idx)) e.data = m_mem[idx];
            else                   e.chk = 1'b0;
        end else if (th) e.data = m_tohost;
        else if (lo)     e.data = cnow[31:0];
        else if (hi)     e.data = m_shadow;
        e.err = !(ram || th || lo || hi) && (we || a < 32'h8000_0000);
        if (lo) m_shadow = cnow[63:32];
        if (we && ram) begin
            if (be == 4'hF)             m_mem[idx] = wd;
            else if (m_mem.exists(idx)) m_mem[idx] = merge(m_mem[idx], wd, be);
        end
        if (we && th) begin
            m_tohost = merge(m_tohost, wd, be);
            if (m_tohost[0]) m_tv = 1'b1;
        end
        e.th = m_tohost;
        e.tv = m_tv;
        q.push_back(e);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return DMEM_BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            3:       return DMEM_BASE + 32'h3FC0 + ($urandom_range(0, 15) << 2);
            4:       return MMIO_BASE + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            5:       return $urandom_range(0, 32'h0FFF_FFFF);
            6:       return 32'h8000_0000 + $urandom_range(0, 32'h7000_0000);
            default: return DMEM_BASE + 32'h4000 + ($urandom_range(0, 63) << 2);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!n_rst) begin
            check(-1, "reset ReadData", 64'(ReadData), 64'h0);
            check(-1, "reset cycle", cycle, 64'h0);
            check(-1, "reset tohost", 64'(tohost), 64'h0);
            check(-1, "reset tohost_valid", 64'(tohost_valid), 64'h0);
            check(-1, "reset addr_err", 64'(addr_err), 64'h0);
        end else begin
            check(-1, "cycle", cycle, model_cycle());
            while (q.size() != 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                if (mon_e.chk) check(mon_e.id, "ReadData", 64'(ReadData), 64'(mon_e.data));
                check(mon_e.id, "addr_err", 64'(addr_err), 64'(mon_e.err));
                check(mon_e.id, "tohost", 64'(tohost), 64'(mon_e.th));
                check(mon_e.id, "tohost_valid", 64'(tohost_valid), 64'(mon_e.tv));
            end
        end
        if (finish_req) begin
            check(-1, "scoreboard drained", 64'(q.size()), 64'h0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0; Addr = DMEM_BASE; WriteData = 32'h0; ByteEnable = 4'h0; MemWrite = 1'b0;
        m_tohost = 32'h0; m_tv = 1'b0; m_shadow = 32'h0;
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;

        // Byte-lane stores and the ByteEnable = 0 no-op.
        issue(DMEM_BASE,          32'h5A5A_0001, 4'hF, 1'b1);
        issue(DMEM_BASE + 32'h10, 32'hAABB_CCDD, 4'hF, 1'b1);
        issue(DMEM_BASE + 32'h10, 32'h0011_0000, 4'b0100, 1'b1);
        issue(DMEM_BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b1);
        issue(DMEM_BASE + 32'h10, 32'h0, 4'h0, 1'b0);
        issue(DMEM_BASE + 32'h13, 32'h0, 4'h0, 1'b0);

        // Read-before-write on the same word.
        issue(DMEM_BASE + 32'h20, 32'h0, 4'hF, 1'b1);
        issue(DMEM_BASE + 32'h20, 32'h1234_5678, 4'hF, 1'b1);
        issue(DMEM_BASE + 32'h20, 32'h0, 4'h0, 1'b0);

        // Upper RAM bound and the first address past it.
        issue(DMEM_BASE + 32'h3FFC, 32'hCAFE_F00D, 4'hF, 1'b1);
        issue(DMEM_BASE + 32'h3FFC, 32'h0, 4'h0, 1'b0);
        issue(DMEM_BASE + 32'h4000, 32'h0, 4'h0, 1'b0);
        issue(DMEM_BASE,            32'h0, 4'h0, 1'b0);
        issue(DMEM_BASE + 32'h4000, 32'hDEAD_BEEF, 4'hF, 1'b1);
        issue(DMEM_BASE,            32'h0, 4'h0, 1'b0);
        issue(32'h0000_0100, 32'h0, 4'h0, 1'b0);
        issue(32'h9000_0000, 32'h0, 4'h0, 1'b0);
        issue(32'h9000_0000, 32'h1, 4'hF, 1'b1);

        // tohost mailbox and its sticky valid.
        issue(TOHOST, 32'h0000_0002, 4'hF, 1'b1);
        issue(TOHOST, 32'h0, 4'h0, 1'b0);
        issue(TOHOST, 32'h0000_0001, 4'hF, 1'b1);
        issue(TOHOST, 32'h0, 4'hF, 1'b1);
        issue(TOHOST, 32'h0, 4'h0, 1'b0);

        // Counter coherence across a low-word carry.
        issue(DMEM_BASE, 32'h0, 4'h0, 1'b0);
        #1 force dut.r_cycle = 64'h0000_0007_FFFF_FFFE;
        #1 release dut.r_cycle;
        cyc_offset = 64'h0000_0007_FFFF_FFFE - edges;
        issue(CYC_LO, 32'h0, 4'h0, 1'b0);
        issue(CYC_HI, 32'h0, 4'h0, 1'b0);
        issue(CYC_LO, 32'h0000_1234, 4'hF, 1'b1);
        issue(CYC_HI, 32'hFFFF_FFFF, 4'hF, 1'b1);
        issue(CYC_HI, 32'h0, 4'h0, 1'b0);

        // Reset asserted while a store is presented: the store is dropped.
        issue(DMEM_BASE + 32'h40, 32'h600D_F00D, 4'hF, 1'b1);
        issue(DMEM_BASE + 32'h40, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_rst = 1'b0; Addr = DMEM_BASE + 32'h40; WriteData = 32'hBAD0_BAD0;
        ByteEnable = 4'hF; MemWrite = 1'b1;
        @(posedge clk);
        #2;
        n_rst = 1'b1; MemWrite = 1'b0;
        m_tohost = 32'h0; m_tv = 1'b0; m_shadow = 32'h0; cyc_offset = 0;
        issue(CYC_HI, 32'h0, 4'h0, 1'b0);
        issue(DMEM_BASE + 32'h40, 32'h0, 4'h0, 1'b0);
        issue(TOHOST, 32'h0, 4'h0, 1'b0);

        // Randomized traffic over every region of the map.
        repeat (300) begin
            logic [31:0] a;
            logic [3:0]  be;
            logic        we;
            a  = rand_addr();
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            we = 1'($urandom_range(0, 1));
            issue(a, $urandom, be, we);
        end

        repeat (3) @(negedge clk);
        #1 finish_req = 1'b1;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the CPU's M/W-stage data port. It accepts the pipeline's byte-lane-aligned store requests and returns full read words one cycle later, timed for W-stage capture. It also decodes a small MMIO window containing a tohost mailbox and a free-running 64-bit cycle counter. Byte extraction and sign extension stay in the CPU's load-side byte-enable logic; this block always returns whole aligned words.

Parameters:
DMEM_BASE, 32'h1000_0000, byte base address of the RAM region
ADDR_WIDTH, 12, word-address bits (RAM depth = 2**ADDR_WIDTH words)
MMIO_BASE, 32'hFFFF_0000, base of MMIO window (tohost +0x0, cycle_lo +0x4, cycle_hi +0x8)

Ports:
clk  input  1  clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
Addr  input  32  byte address from M stage; Addr[1:0] ignored for decode
WriteData  input  32  store data, already lane-shifted
ByteEnable  input  4  per-lane write enable, bit i = bits [8i+7:8i]
MemWrite  input  1  store strobe, qualifies ByteEnable
ReadData  output  32  registered word read of the previous cycle's Addr
tohost  output  32  mailbox register contents
tohost_valid  output  1  sticky, set when a tohost write leaves bit0 = 1
addr_err  output  1  registered one-cycle flag: previous Addr decoded to no target
cycle  output  64  free-running cycle counter

Behaviour:
- Reset (n_rst low, asynchronous): ReadData = 0, tohost = 0, tohost_valid = 0, addr_err = 0, cycle = 0, cycle_hi shadow = 0. RAM contents are not reset.
- Decode uses word address Addr[31:2]:
  - RAM hit: DMEM_BASE <= Addr < DMEM_BASE + 4*2**ADDR_WIDTH. Index = (Addr - DMEM_BASE) >> 2.
  - MMIO hit: Addr[31:2] equals MMIO_BASE[31:2] + 0, 1 or 2.
  - Anything else is a miss.
- Reads: no read enable; a read is performed every cycle. ReadData(n+1) = target word at Addr(n).
  - MMIO reads: tohost; cycle[31:0]; cycle_hi shadow.
  - Miss reads return 32'h0.
- Writes: when MemWrite = 1 at edge n, each lane i with ByteEnable[i] = 1 is written. Lanes with ByteEnable = 0 keep their old value.
  - MemWrite = 1 with ByteEnable = 0 is a no-op.
- Same-cycle read and write to the same word: ReadData returns the OLD word (read-before-write). The next cycle's read sees the new value, so a store followed immediately by a load needs no stall.
- tohost writes: byte-enabled like RAM. tohost_valid is set on the edge after a write whose resulting tohost[0] = 1. It stays set until reset; later writes, including ones writing bit0 = 0, do not clear it.
- Cycle counter: cycle increments by 1 every clock after reset release and wraps from 2**64-1 to 0.
  - A read of cycle_lo latches cycle[63:32] into the cycle_hi shadow on that same edge, so a lo-then-hi read pair is coherent.
  - A read of cycle_hi returns the shadow, which is 0 if cycle_lo was never read.
  - Writes to cycle_lo/cycle_hi are ignored and do not raise addr_err.
- addr_err(n+1) = 1 iff cycle n is a miss AND (MemWrite = 1 OR the address is in 0x0000_0000–0x7FFF_FFFF). Speculative garbage reads from ALU results above 0x8000_0000 are not flagged.
  - Missed writes are dropped and change no state.
- Misaligned Addr[1:0] is legal; alignment is the CPU's responsibility via ByteEnable.
- Reset asserted mid-store: the store is dropped if reset is low at the edge; RAM may keep any prior value.
- RAM must infer as a single-port synchronous block RAM with byte write enables.

Test Plan:
- Reset: hold n_rst = 0 for 3 cycles with Addr = DMEM_BASE -> ReadData = 0, cycle = 0, tohost_valid = 0, addr_err = 0. Release -> cycle = 1 after the first edge.
- Byte-lane store: write 32'hAABBCCDD full-word to 0x1000_0010, then ByteEnable = 4'b0100, WriteData = 32'h0011_0000 -> readback 32'hAA11CCDD. A second store with MemWrite = 1, ByteEnable = 0 leaves it unchanged.
- Collision: store 32'h1234_5678 to 0x1000_0020 (old value 32'h0) in cycle n, read the same address in n+1 -> ReadData(n+1) = 32'h0, ReadData(n+2) = 32'h1234_5678.
- Bounds: read 0x1000_3FFC with ADDR_WIDTH = 12 -> valid data, addr_err = 0. Read 0x1000_4000 -> ReadData = 0, addr_err = 1 for exactly one cycle. Write there -> no RAM word changes (check 0x1000_0000).
- tohost: write 32'h0000_0002 -> tohost_valid = 0. Write 32'h0000_0001 -> tohost_valid = 1 on the next cycle. Write 32'h0 -> tohost = 0, tohost_valid stays 1.
- Counter coherence: force cycle to 32'hFFFF_FFFF in the low word, read cycle_lo then cycle_hi on consecutive cycles -> lo = 32'hFFFF_FFFF and hi = pre-carry value. A write to cycle_lo leaves the count sequence unchanged and addr_err = 0.
